// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types: counter encodings, FSM states, saturating update
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cur == ST) ? ST : cur + 2'd1;
        end else begin
            nxt = (cur == SNT) ? SNT : cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pht_array.sv
// rtl/pht_array.sv - 2-bit counter storage: two combinational read ports, one synchronous write port
module pht_array #(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [1:0]       wdata_i,
    input  logic [IDX_W-1:0] raddr_a_i,
    output logic [1:0]       rdata_a_o,
    input  logic [IDX_W-1:0] raddr_b_i,
    output logic [1:0]       rdata_b_o
);

    logic [1:0] mem_q [0:(1<<IDX_W)-1];

    // No reset here: contents are established by the owner's INIT sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pht_update_unit.sv
// rtl/pht_update_unit.sv - gshare PHT with two-stage update pipeline, bypassing and INIT sweep
module pht_update_unit
    import bp_pkg::*;
#(
    parameter int PHT_IDX_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 pred_taken,
    output logic [PHT_IDX_W-1:0] pred_index,
    input  logic                 upd_valid,
    input  logic [PHT_IDX_W-1:0] upd_index,
    input  logic                 upd_taken,
    output logic                 init_busy
);

    localparam logic [PHT_IDX_W-1:0] LAST_IDX = '1;

    state_t               state_q;
    logic [PHT_IDX_W-1:0] init_cnt_q;
    logic [PHT_IDX_W-1:0] ghr_q;
    logic                 pred_taken_q;
    logic [PHT_IDX_W-1:0] pred_index_q;
    logic                 init_busy_q;
    logic                 u2_valid_q;
    logic [PHT_IDX_W-1:0] u2_idx_q;
    logic [1:0]           u2_ctr_q;

    logic                 run;
    logic [PHT_IDX_W-1:0] lookup_idx;
    logic [1:0]           lk_rd, u1_rd, lk_ctr, u1_old;
    logic                 we;
    logic [PHT_IDX_W-1:0] waddr;
    logic [1:0]           wdata;
    logic                 unused_bits;

    assign run        = (state_q == S_RUN);
    assign lookup_idx = pred_pc[PHT_IDX_W+1:2] ^ ghr_q;

    // The U2 write has not landed yet, so both readers take it from the pipeline register.
    assign u1_old = (u2_valid_q && (u2_idx_q == upd_index))  ? u2_ctr_q : u1_rd;
    assign lk_ctr = (u2_valid_q && (u2_idx_q == lookup_idx)) ? u2_ctr_q : lk_rd;

    // Reset suppresses any write, dropping a pending U2 update.
    assign we    = !rst && (run ? u2_valid_q : 1'b1);
    assign waddr = run ? u2_idx_q : init_cnt_q;
    assign wdata = run ? u2_ctr_q : WNT;

    assign unused_bits = ^{pred_pc[31:PHT_IDX_W+2], pred_pc[1:0], lk_ctr[0]};

    pht_array #(.IDX_W(PHT_IDX_W)) u_pht_array (
        .clk       (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (lookup_idx),
        .rdata_a_o (lk_rd),
        .raddr_b_i (upd_index),
        .rdata_b_o (u1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            ghr_q        <= '0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            init_busy_q  <= 1'b1;
            u2_valid_q   <= 1'b0;
            u2_idx_q     <= '0;
            u2_ctr_q     <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_cnt_q   <= init_cnt_q + 1'b1;
                    pred_taken_q <= 1'b0;
                    u2_valid_q   <= 1'b0;
                    if (init_cnt_q == LAST_IDX) begin
                        state_q     <= S_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    u2_valid_q <= upd_valid;
                    if (upd_valid) begin
                        u2_idx_q <= upd_index;
                        u2_ctr_q <= sat_next(u1_old, upd_taken);
                        ghr_q    <= {ghr_q[PHT_IDX_W-2:0], upd_taken};
                    end
                    if (pred_valid) begin
                        pred_taken_q <= lk_ctr[1];
                        pred_index_q <= lookup_idx;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign pred_taken = pred_taken_q;
    assign pred_index = pred_index_q;
    assign init_busy  = init_busy_q;

endmodule

// File: tb/tb_pht_update_unit.sv
// tb/tb_pht_update_unit.sv - directed self-checking bench for pht_update_unit
module tb_pht_update_unit;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [6:0]  pred_index;
    logic        upd_valid;
    logic [6:0]  upd_index;
    logic        upd_taken;
    logic        init_busy;

    int   n_cmp;
    int   n_fail;
    logic [6:0] ghr_m;

    pht_update_unit #(.PHT_IDX_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_valid (pred_valid),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .pred_index (pred_index),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .init_busy  (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [6:0] idx, input logic taken);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = taken;
        tick();
        ghr_m     = {ghr_m[5:0], taken};
        upd_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [6:0] idx);
        logic [6:0] pc_bits;
        pc_bits    = idx ^ ghr_m;
        pred_pc    = {23'd0, pc_bits, 2'b00};
        pred_valid = 1'b1;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        ghr_m = '0;
        for (int i = 0; i < 128; i++) begin
            n_cmp += 3;
            if (init_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL init_busy_high cycle %0d: got %b want 1", i, init_busy);
            end
            if (pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL init_pred_taken cycle %0d: got %b want 0", i, pred_taken);
            end
            if (pred_index !== 7'd0) begin
                n_fail++;
                $display("FAIL init_pred_index cycle %0d: got %0d want 0", i, pred_index);
            end
            pred_valid = 1'b1;
            pred_pc    = $urandom;
            upd_valid  = 1'b1;
            upd_index  = 7'(i);
            upd_taken  = 1'b1;
            tick();
        end
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        n_cmp++;
        if (init_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_busy_low: got %b want 0", init_busy);
        end
        for (int k = 0; k < 128; k += 9) begin
            do_lookup(7'(k));
            n_cmp += 2;
            if (pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL post_init_taken idx %0d: got %b want 0", k, pred_taken);
            end
            if (pred_index !== 7'(k)) begin
                n_fail++;
                $display("FAIL post_init_index idx %0d: got %0d want %0d", k, pred_index, k);
            end
        end
    endtask

    task automatic test_ghr();
        do_update(7'd20, 1'b1);
        tick();
        do_update(7'd21, 1'b0);
        tick();
        do_update(7'd22, 1'b1);
        tick();
        tick();
        pred_pc    = 32'h0000_0014;
        pred_valid = 1'b1;
        tick();
        pred_valid = 1'b0;
        n_cmp += 2;
        if (pred_index !== 7'h00) begin
            n_fail++;
            $display("FAIL ghr_index: got %0h want 0", pred_index);
        end
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL ghr_taken: got %b want 0", pred_taken);
        end
    endtask

    task automatic test_saturation();
        logic exp_t [0:4];
        logic dir   [0:4];
        exp_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        dir   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int s = 0; s < 5; s++) begin
            do_update(7'd5, dir[s]);
            tick();
            tick();
            do_lookup(7'd5);
            n_cmp += 2;
            if (pred_taken !== exp_t[s]) begin
                n_fail++;
                $display("FAIL sat_step%0d taken: got %b want %b", s, pred_taken, exp_t[s]);
            end
            if (pred_index !== 7'd5) begin
                n_fail++;
                $display("FAIL sat_step%0d index: got %0d want 5", s, pred_index);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_update(7'd9, 1'b1);
        do_update(7'd9, 1'b1);
        tick();
        tick();
        do_update(7'd9, 1'b0);
        tick();
        tick();
        do_lookup(7'd9);
        n_cmp += 2;
        if (pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_taken: got %b want 1", pred_taken);
        end
        if (pred_index !== 7'd9) begin
            n_fail++;
            $display("FAIL b2b_index: got %0d want 9", pred_index);
        end
    endtask

    task automatic test_collision();
        do_update(7'd3, 1'b1);
        do_lookup(7'd3);
        n_cmp += 2;
        if (pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_taken: got %b want 1", pred_taken);
        end
        if (pred_index !== 7'd3) begin
            n_fail++;
            $display("FAIL collide_index: got %0d want 3", pred_index);
        end
        pred_pc = 32'h0000_0100;
        tick();
        n_cmp += 2;
        if (pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_taken: got %b want 1", pred_taken);
        end
        if (pred_index !== 7'd3) begin
            n_fail++;
            $display("FAIL hold_index: got %0d want 3", pred_index);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        do_update(7'd7, 1'b1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        ghr_m = '0;
        n_cmp += 3;
        if (init_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy: got %b want 1", init_busy);
        end
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_taken: got %b want 0", pred_taken);
        end
        if (pred_index !== 7'd0) begin
            n_fail++;
            $display("FAIL rst_index: got %0d want 0", pred_index);
        end
        n = 0;
        while (init_busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != 128) begin
            n_fail++;
            $display("FAIL reinit_cycles: got %0d want 128", n);
        end
        do_lookup(7'd7);
        n_cmp += 2;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_entry7_taken: got %b want 0", pred_taken);
        end
        if (pred_index !== 7'd7) begin
            n_fail++;
            $display("FAIL reinit_entry7_index: got %0d want 7", pred_index);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        ghr_m      = '0;
        rst        = 1'b1;
        pred_valid = 1'b0;
        pred_pc    = '0;
        upd_valid  = 1'b0;
        upd_index  = '0;
        upd_taken  = 1'b0;
        test_reset();
        test_ghr();
        test_saturation();
        test_back_to_back();
        test_collision();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pht_update_unit.md
PHT_UPDATE_UNIT -- requirements
Module: pht_update_unit

Interface
REQ-001 SHALL have parameter PHT_IDX_W, default 7, meaning log2 of PHT entry count (128 entries).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pred_valid  input  1  fetch-stage lookup request.
REQ-005 SHALL have port pred_pc  input  32  fetch PC of lookup.
REQ-006 SHALL have port pred_taken  output  1  predicted direction (counter MSB).
REQ-007 SHALL have port pred_index  output  PHT_IDX_W  index used; carried down pipeline for update.
REQ-008 SHALL have port upd_valid  input  1  execute-stage branch resolved.
REQ-009 SHALL have port upd_index  input  PHT_IDX_W  index returned with resolved branch.
REQ-010 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-011 SHALL have port init_busy  output  1  high while table initialisation runs.

Function
REQ-012 SHALL form lookup index = pred_pc[PHT_IDX_W+1:2] XOR ghr (gshare), ghr a PHT_IDX_W-bit global history register.
REQ-013 SHALL register pred_taken/pred_index one cycle after pred_valid; hold prior values when pred_valid low.
REQ-014 SHALL hold each entry as 2-bit saturating counter: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
REQ-015 SHALL compute next counter: taken -> increment, saturate at 11; not taken -> decrement, saturate at 00.
REQ-016 SHALL process updates in 2 stages: U1 (cycle of upd_valid) captures index/outcome and reads old counter; U2 (next cycle) writes new counter.
REQ-017 SHALL shift ghr left by one, inserting upd_taken at bit 0, at the clock edge ending the upd_valid cycle (non-speculative history).
REQ-018 SHALL forward U2 write value into U1 read when indices match (back-to-back updates to same entry count twice).
REQ-019 SHALL return U2 write value to a same-cycle lookup of the same index (write-before-read).
REQ-020 SHALL accept one update per cycle with no backpressure; upd_valid every cycle SHALL lose no update.
REQ-021 SHALL implement FSM states INIT and RUN: INIT writes 01 to one entry per cycle, index 0 upward; after last entry -> RUN.
REQ-022 SHALL in INIT assert init_busy, drive pred_taken=0, ignore pred_valid and upd_valid, and hold ghr at 0.
REQ-023 SHALL in RUN deassert init_busy; no return to INIT except via rst.
REQ-024 SHALL let index wrap modulo 2^PHT_IDX_W; no out-of-range access.

Reset
REQ-025 SHALL on rst: enter INIT, clear init counter to 0, ghr=0, pred_taken=0, pred_index=0, init_busy=1, invalidate U1/U2.
REQ-026 SHALL on rst asserted mid-INIT or mid-update: restart INIT from entry 0; drop any pending U2 write.
REQ-027 SHALL reach RUN exactly 2^PHT_IDX_W cycles after rst deasserts.

Structure
REQ-028 SHALL place counter encodings (SNT/WNT/WT/ST), FSM state enum, and saturating next-state function in shared package bp_pkg.
REQ-029 SHALL instantiate one sub-module pht_array: 1 read port for lookup, 1 read port for U1, 1 write port, synchronous write.
REQ-030 SHALL keep ghr, FSM, U1/U2 registers, and bypass muxes in pht_update_unit.

Verification
REQ-031 SHALL test init: rst 1 cycle -> init_busy high 128 cycles, then low; every lookup returns pred_taken=0 (entries 01).
REQ-032 SHALL test saturation: 3 updates taken, index 5, spaced -> counter 01->10->11->11; lookup index 5 -> pred_taken=1.
REQ-033 SHALL test back-to-back: upd_valid 2 consecutive cycles, index 9, taken -> counter 11 (bypass), not 10.
REQ-034 SHALL test write/read collision: U2 writing 10 to index 3 while lookup hits index 3 -> pred_taken=1 next cycle.
REQ-035 SHALL test ghr: ghr=0, updates taken,NT,taken -> ghr=0000101; lookup pred_pc=0x14 -> pred_index=0x05 XOR 0x05=0x00.
REQ-036 SHALL test reset mid-run: rst during pending U2 write to index 7 -> entry 7 reads 01 after re-init; ghr=0.
